// File: rtl/fa4_dual_adder.sv
// rtl/fa4_dual_adder.sv - registered 4-bit adder pair: full-adder ripple chain vs behavioural add
//
// Computes a + b + ci two ways in parallel. One path is a ripple chain of
// fa4_full_adder instances. The other path is a single 5-bit behavioural add.
// Both results are captured on the same edge and presented side by side.
//
// Optional feature macro: FA4_CROSSCHECK_EN
//   defined   - compares {co1,s1} with {co2,s2}; drives a registered mismatch
//               flag and a sticky error flag
//   undefined - mismatch and err_sticky are tied to 0; no comparator is built
//
// Ports:
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   in_valid   in   1  operands valid this cycle
//   a, b       in   4  unsigned operands
//   ci         in   1  carry-in
//   out_valid  out  1  registered results valid (in_valid delayed one cycle)
//   s1, co1    out  4/1 ripple-chain sum and carry-out
//   s2, co2    out  4/1 behavioural sum and carry-out
//   mismatch   out  1  registered {co1,s1} != {co2,s2}
//   err_sticky out  1  set by any captured mismatch; cleared only by rst

// One-bit full adder used as the ripple stage.
module fa4_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module fa4_dual_adder (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic       out_valid,
  output logic [3:0] s1,
  output logic       co1,
  output logic [3:0] s2,
  output logic       co2,
  output logic       mismatch,
  output logic       err_sticky
);

  // Ripple path: carry[0] is the carry-in, carry[4] the carry-out.
  logic [4:0] carry;
  logic [3:0] rs;

  assign carry[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_ripple
    fa4_full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (carry[i]),
      .s  (rs[i]),
      .co (carry[i+1])
    );
  end

  // Behavioural path: widen every term to 5 bits so the carry is not lost.
  logic [4:0] bsum;
  assign bsum = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      s1        <= 4'h0;
      co1       <= 1'b0;
      s2        <= 4'h0;
      co2       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s1  <= rs;
        co1 <= carry[4];
        s2  <= bsum[3:0];
        co2 <= bsum[4];
      end
    end
  end

`ifdef FA4_CROSSCHECK_EN
  logic mismatch_c;
  assign mismatch_c = ({carry[4], rs} != bsum);

  // err_sticky rises on the same edge that captures a mismatch, so both
  // flags become visible together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
    end else if (in_valid) begin
      mismatch   <= mismatch_c;
      err_sticky <= err_sticky | mismatch_c;
    end
  end
`else
  assign mismatch   = 1'b0;
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_fa4_dual_adder.sv
// tb/tb_fa4_dual_adder.sv - randomized and directed self-checking bench for fa4_dual_adder
module tb_fa4_dual_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic       ci = 1'b0;
  logic       out_valid;
  logic [3:0] s1;
  logic       co1;
  logic [3:0] s2;
  logic       co2;
  logic       mismatch;
  logic       err_sticky;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the outputs should show right now.
  int exp_valid = 0;
  int exp_s     = 0;
  int exp_co    = 0;
  int exp_mm    = 0;
  int exp_err   = 0;

  fa4_dual_adder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .a          (a),
    .b          (b),
    .ci         (ci),
    .out_valid  (out_valid),
    .s1         (s1),
    .co1        (co1),
    .s2         (s2),
    .co2        (co2),
    .mismatch   (mismatch),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out_valid"},  int'(out_valid),  exp_valid);
    check({tag, ".s1"},         int'(s1),         exp_s);
    check({tag, ".co1"},        int'(co1),        exp_co);
    check({tag, ".s2"},         int'(s2),         exp_s);
    check({tag, ".co2"},        int'(co2),        exp_co);
    check({tag, ".mismatch"},   int'(mismatch),   exp_mm);
    check({tag, ".err_sticky"}, int'(err_sticky), exp_err);
  endtask

  // Drive one cycle of stimulus, advance past the edge, update the model, check.
  task automatic step(input string tag, input int v, input int av, input int bv, input int cv);
    int total;
    @(negedge clk);
    in_valid = v[0];
    a        = av[3:0];
    b        = bv[3:0];
    ci       = cv[0];
    @(posedge clk);
    #1;
    exp_valid = v;
    if (v != 0) begin
      total  = av + bv + cv;
      exp_s  = total % 16;
      exp_co = total / 16;
      exp_mm = 0;
    end
    check_all(tag);
  endtask

  task automatic model_reset();
    exp_valid = 0;
    exp_s     = 0;
    exp_co    = 0;
    exp_mm    = 0;
    exp_err   = 0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed cases, including boundary sums
    step("d_3p4",     1, 3,  4,  0);
    step("d_15p15p1", 1, 15, 15, 1);
    step("d_15p0p1",  1, 15, 0,  1);
    step("d_zero",    1, 0,  0,  0);

    // Exhaustive sweep of {ci,a,b}
    for (int i = 0; i < 512; i++) begin
      step("sweep", 1, (i >> 4) & 15, i & 15, (i >> 8) & 1);
    end

    // Hold: capture 9+6+1, then drop in_valid with different operands
    step("hold_cap", 1, 9, 6, 1);
    step("hold_idle1", 0, 7, 3, 0);
    step("hold_idle2", 0, 14, 12, 1);

    // Random stream with random valid gaps
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 3) != 0) ? 1 : 0,
           $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
    end

    // Reset between edges after a nonzero result
    step("pre_rst", 1, 11, 7, 1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    a        = 4'd6;
    b        = 4'd5;
    ci       = 1'b1;
    @(posedge clk);
    #1;
    exp_valid = 1;
    exp_s     = 12;
    exp_co    = 0;
    check_all("rst_release");
    step("post_rst", 1, 8, 8, 0);

`ifdef FA4_CROSSCHECK_EN
    // Corrupt the ripple sum: 0+0+0 through a forced ripple bit reads 1.
    @(negedge clk);
    force dut.rs = 4'b0001;
    in_valid = 1'b1;
    a        = 4'd0;
    b        = 4'd0;
    ci       = 1'b0;
    @(posedge clk);
    #1;
    check("xc.mismatch",   int'(mismatch),   1);
    check("xc.err_sticky", int'(err_sticky), 1);
    check("xc.s1",         int'(s1),         1);
    check("xc.s2",         int'(s2),         0);
    release dut.rs;
    exp_valid = 1;
    exp_s     = 0;
    exp_co    = 0;
    exp_mm    = 1;
    exp_err   = 1;
    step("xc_clean", 1, 2, 3, 0);
    step("xc_clean2", 1, 4, 4, 1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("xc_rst");
    @(negedge clk);
    rst = 1'b0;
    step("xc_after", 1, 1, 1, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
